// File: rtl/alu_nibble_sequencer.sv
// Runs one shared 4-bit ALU slice over a wide operand, one nibble per cycle, LSB first,
// chaining carry through a register and producing full-width result, zero, carry and SLT flags.
module alu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic [2:0]             op,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   zero,
   output logic                   set,
   output logic                   illegal_op,
   output logic [3:0]             slice_a,
   output logic [3:0]             slice_b,
   output logic                   slice_cin,
   output logic                   slice_less,
   output logic [2:0]             slice_op,
   input  logic [3:0]             slice_result,
   input  logic                   slice_cout,
   input  logic                   slice_set
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic [W-1:0]    result_q, result_d;
   logic            cout_q, cout_d, zero_q, zero_d, set_q, set_d;
   logic            illegal_q, illegal_d, done_q, done_d, busy_q, busy_d;
   logic            isArith, isSub, isSlt, isIllegal;

   always_comb begin
      isArith   = (op_q == 3'b010) || (op_q == 3'b110) || (op_q == 3'b111);
      isSub     = (op_q == 3'b110) || (op_q == 3'b111);
      isSlt     = (op_q == 3'b111);
      isIllegal = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);
   end

   // The slice only ever sees latched copies; SLT runs as a subtract and is fixed up at the end.
   always_comb begin
      slice_a    = a_q[4*idx_q +: 4];
      slice_b    = b_q[4*idx_q +: 4];
      slice_cin  = (idx_q == '0) ? op_q[2] : carry_q;
      slice_less = 1'b0;
      slice_op   = isSlt ? 3'b110 : op_q;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      result_d  = result_q;
      cout_d    = cout_q;
      zero_d    = zero_q;
      set_d     = set_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               op_d     = op;
               idx_d    = '0;
               carry_d  = 1'b0;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[4*idx_q +: 4] = slice_result;
            carry_d                = slice_cout;
            if (idx_q == LAST_IDX) begin
               // Flags come from the top nibble; substitutions happen before zero is judged.
               if (isSlt) begin
                  result_d    = '0;
                  result_d[0] = slice_set;
               end
               if (isIllegal) begin
                  result_d = '0;
               end
               cout_d    = isArith ? slice_cout : 1'b0;
               set_d     = isSub ? slice_set : 1'b0;
               illegal_d = isIllegal;
               zero_d    = (result_d == '0);
               state_d   = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      done_d = (state_q == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         zero_q    <= 1'b0;
         set_q     <= 1'b0;
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         result_q  <= result_d;
         cout_q    <= cout_d;
         zero_q    <= zero_d;
         set_q     <= set_d;
         illegal_q <= illegal_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign result     = result_q;
   assign cout       = cout_q;
   assign zero       = zero_q;
   assign set        = set_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU slice attached.
module tb_alu_nibble_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [2:0]  op = '0;
   logic        busy, done, cout, zero, set, illegal_op;
   logic [15:0] result;
   logic [3:0]  sliceA, sliceB, sliceResult;
   logic        sliceCin, sliceLess, sliceCout, sliceSet;
   logic [2:0]  sliceOp;

   int compared = 0;
   int mismatched = 0;
   int lat;
   int doneCount;
   logic [15:0] seenResult;

   always #5 clk = ~clk;

   alu_nibble_sequencer #(.NIBBLES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
      .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
      .set(set), .illegal_op(illegal_op),
      .slice_a(sliceA), .slice_b(sliceB), .slice_cin(sliceCin), .slice_less(sliceLess),
      .slice_op(sliceOp), .slice_result(sliceResult), .slice_cout(sliceCout),
      .slice_set(sliceSet)
   );

   // Reference slice: inverts B itself for op[2]=1, set is the MSB of the sum.
   logic [3:0] bEff;
   logic [4:0] sum;
   always_comb begin
      bEff = sliceOp[2] ? ~sliceB : sliceB;
      sum  = {1'b0, sliceA} + {1'b0, bEff} + {4'b0, sliceCin};
      case (sliceOp)
         3'b000:  sliceResult = sliceA & sliceB;
         3'b001:  sliceResult = sliceA | sliceB;
         default: sliceResult = sum[3:0];
      endcase
      sliceCout = sum[4];
      sliceSet  = sum[3];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one op and waits (bounded) for done; lat counts cycles after the start-sampling edge.
   task automatic applyStimulus(input logic [2:0] opv, input logic [15:0] av, input logic [15:0] bv,
                                output int latency);
      @(negedge clk);
      start = 1'b1; op = opv; a = av; b = bv;
      @(negedge clk);
      start = 1'b0;
      latency = 1;
      while (done !== 1'b1 && latency < 20) begin
         @(negedge clk);
         latency++;
      end
   endtask

   task automatic checkOp(input string tag, input logic [15:0] expRes, input logic expCout,
                          input logic expZero, input logic expSet, input logic expIll);
      checkOutput({tag, "_latency"}, lat, 6);
      checkOutput({tag, "_result"}, result, expRes);
      checkOutput({tag, "_cout"}, cout, expCout);
      checkOutput({tag, "_zero"}, zero, expZero);
      checkOutput({tag, "_set"}, set, expSet);
      checkOutput({tag, "_illegal"}, illegal_op, expIll);
      @(negedge clk);
      checkOutput({tag, "_donePulse"}, done, 1'b0);
   endtask

   initial begin
      // Reset for two cycles, then try a start while reset is still held.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_result", result, 16'h0000);
      checkOutput("rst_flags", {cout, zero, set, illegal_op}, 4'b0000);
      start = 1'b1; op = 3'b010; a = 16'h0001; b = 16'h0001;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_startHeld_busy", busy, 1'b0);
      start = 1'b0;
      reset = 1'b0;

      // ADD with a long carry chain; also look at busy during the run.
      @(negedge clk);
      start = 1'b1; op = 3'b010; a = 16'h0FFF; b = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      checkOutput("add1_busyRun", busy, 1'b1);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("add1_busyAtDone", busy, 1'b0);
      checkOp("add1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

      applyStimulus(3'b110, 16'h1234, 16'h1234, lat);
      checkOp("subEq", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(3'b010, 16'hFFFF, 16'h0001, lat);
      checkOp("addWrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

      applyStimulus(3'b111, 16'h0003, 16'h0005, lat);
      checkOp("sltLess", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(3'b111, 16'h0005, 16'h0003, lat);
      checkOp("sltGe", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

      applyStimulus(3'b000, 16'hF0F0, 16'hFF00, lat);
      checkOp("and", 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(3'b001, 16'h000F, 16'h00F0, lat);
      checkOp("or", 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(3'b011, 16'h1234, 16'h4321, lat);
      checkOp("illegal", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);

      // Start pulsed mid-run with different operands: must be ignored entirely.
      @(negedge clk);
      start = 1'b1; op = 3'b010; a = 16'h1111; b = 16'h2222;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 3'b110; a = 16'hFFFF; b = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      doneCount = 0;
      seenResult = 16'hDEAD;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) begin
            doneCount++;
            seenResult = result;
         end
         @(negedge clk);
      end
      checkOutput("busyStart_doneCount", doneCount, 1);
      checkOutput("busyStart_result", seenResult, 16'h3333);

      // Reset while idx==2: back to IDLE, cleared outputs, no done afterwards.
      @(negedge clk);
      start = 1'b1; op = 3'b010; a = 16'hAAAA; b = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midRst_busy", busy, 1'b0);
      checkOutput("midRst_result", result, 16'h0000);
      doneCount = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1) doneCount++;
         @(negedge clk);
      end
      checkOutput("midRst_noDone", doneCount, 0);

      applyStimulus(3'b110, 16'h5000, 16'h0001, lat);
      checkOp("afterRst_sub", 16'h4FFF, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
